// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with next-PC selection (sequential, branch, jump, JR,
// exception) and a post-redirect flush window that kills younger in-flight instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [1:0]  redirect_type_i,
    input  logic [31:0] src_pc4_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] RT_BRANCH = 2'b00;
    localparam logic [1:0] RT_JUMP   = 2'b01;
    localparam logic [1:0] RT_JR     = 2'b10;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  count_q, count_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        jr_misaligned;
    logic        redirect_take;
    logic [31:0] redirect_pc;

    assign branch_target = src_pc4_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};
    assign jump_target   = {src_pc4_i[31:28], instr_index_i, 2'b00};
    assign jr_misaligned = (jr_target_i[1:0] != 2'b00);
    // Reserved type 11 is not a redirect at all; it falls through to stall/sequential.
    assign redirect_take = redirect_valid_i && (redirect_type_i != 2'b11);

    always_comb begin
        redirect_pc = jr_target_i;
        case (redirect_type_i)
            RT_BRANCH: redirect_pc = branch_target;
            RT_JUMP:   redirect_pc = jump_target;
            RT_JR:     redirect_pc = jr_misaligned ? EXC_VECTOR : jr_target_i;
            default:   redirect_pc = jr_target_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        misaligned_d = 1'b0;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (exc_i) begin
            pc_d    = EXC_VECTOR;
            state_d = ST_FLUSH;
            count_d = FLUSH_INIT;
        end else if ((state_q == ST_RUN) && redirect_take) begin
            pc_d         = redirect_pc;
            state_d      = ST_FLUSH;
            count_d      = FLUSH_INIT;
            misaligned_d = (redirect_type_i == RT_JR) && jr_misaligned;
        end else if (!stall_i) begin
            pc_d = pc_q + 32'd4;
            // Leaving on the decrement that reaches zero keeps flush_o high FLUSH_CYCLES cycles.
            if (state_q == ST_FLUSH) begin
                if (count_q <= 3'd1) begin
                    count_d = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            count_q      <= 3'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = (state_q != ST_BOOT);
    assign flush_o      = (state_q == ST_FLUSH);
    assign misaligned_o = misaligned_q;

endmodule
